// File: rtl/ew_result_collector.sv
// ---------------------------------------------------------------------------
// ew_result_collector
//
// Purpose:
//    Sink-side companion of the 8-lane elementwise quantized ALU blocks.
//    Captures the unbackpressured ALU result stream into a FIFO and re-emits
//    it as an AXI-Stream master. tlast/tkeep are derived from the programmed
//    element count. A registered credit (issue_ok) lets upstream issue logic
//    pace the ALU so that no result beat is ever lost.
//
// Ports:
//    clk, rst          clock (rising edge) and synchronous active-high reset
//    start             1-cycle pulse, begins a job when IDLE
//    total_elems       number of int8 results in the job
//    valid_i, data_i   ALU result beat (lane k = bits[8k+7:8k])
//    issue_ok          registered credit: upstream may issue this cycle
//    m_axis_*          AXI-Stream master toward the output buffer writer
//    busy              high while a job is running
//    done              1-cycle pulse at job end
//    overflow          sticky: a result beat was dropped
//
// FIFO_DEPTH must be a power of 2 and larger than PIPE_DEPTH+1.
// ---------------------------------------------------------------------------
module ew_result_collector #(
   parameter int MAX_VECTOR_SIZE = 8,
   parameter int FIFO_DEPTH      = 16,
   parameter int PIPE_DEPTH      = 6,
   parameter int INT8_SIZE       = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [31:0]                          total_elems,
   input  logic                                 valid_i,
   input  logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] data_i,
   output logic                                 issue_ok,
   output logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] m_axis_tdata,
   output logic [MAX_VECTOR_SIZE-1:0]           m_axis_tkeep,
   output logic                                 m_axis_tlast,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overflow
);

   localparam int DW = INT8_SIZE * MAX_VECTOR_SIZE;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(MAX_VECTOR_SIZE);
   // Beat counters hold ceil(2^32 / lanes), i.e. one bit more than 32-LW.
   localparam int CW = 33 - LW;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] beats_q, beats_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] issued_cnt_q, issued_cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          issue_ok_q, issue_ok_d;
   logic          done_q, done_d;
   logic          overflow_q, overflow_d;

   logic [DW-1:0] fifo_mem_q [FIFO_DEPTH];

   logic                       push;
   logic                       pop;
   logic                       last_beat;
   logic [MAX_VECTOR_SIZE-1:0] lane_keep;
   logic [DW-1:0]              head;

   // Output beat presentation: head of FIFO, tlast from the output beat
   // counter, and partial-beat lane masking on the final beat. Everything is
   // gated by tvalid so the bus reads all-zero whenever nothing is presented.
   always_comb begin
      head          = fifo_mem_q[rd_ptr_q];
      m_axis_tvalid = (count_q != '0);
      last_beat     = m_axis_tvalid && (out_cnt_q == beats_q - CW'(1));
      m_axis_tlast  = last_beat;
      lane_keep     = '0;
      m_axis_tdata  = '0;
      for (int k = 0; k < MAX_VECTOR_SIZE; k++) begin
         lane_keep[k] = m_axis_tvalid &&
                        (!last_beat || (rem_q == '0) || (k < int'(rem_q)));
         m_axis_tdata[k*INT8_SIZE +: INT8_SIZE] =
            lane_keep[k] ? head[k*INT8_SIZE +: INT8_SIZE] : '0;
      end
      m_axis_tkeep  = lane_keep;
   end

   // Next-state logic: job control, FIFO bookkeeping, drop detection and
   // the credit computation.
   always_comb begin
      state_d      = state_q;
      beats_d      = beats_q;
      rem_d        = rem_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      issued_cnt_d = issued_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      done_d       = 1'b0;
      overflow_d   = overflow_q;

      pop  = m_axis_tvalid && m_axis_tready;
      // A full FIFO still accepts a beat when the head leaves in the same
      // cycle; the count is then unchanged.
      push = valid_i && (state_q == ST_RUN) && (in_cnt_q != beats_q) &&
             ((count_q != (AW+1)'(FIFO_DEPTH)) || pop);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               overflow_d = 1'b0;
               if (total_elems != '0) begin
                  state_d      = ST_RUN;
                  beats_d      = CW'(total_elems >> LW) +
                                 CW'(|total_elems[LW-1:0]);
                  rem_d        = total_elems[LW-1:0];
                  in_cnt_d     = '0;
                  out_cnt_d    = '0;
                  issued_cnt_d = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         default: begin
            if (pop && last_beat) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase

      if (push) begin
         in_cnt_d = in_cnt_q + CW'(1);
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         out_cnt_d = out_cnt_q + CW'(1);
         rd_ptr_d  = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW+1)'(1);
      end

      if (issue_ok_q) begin
         issued_cnt_d = issued_cnt_q + CW'(1);
      end

      // A dropped beat wins over the clear-on-start so it is never hidden.
      if (valid_i && !push) begin
         overflow_d = 1'b1;
      end

      // Credit uses next-cycle occupancy and issue count: a vector issued
      // while issue_ok is high lands at most PIPE_DEPTH cycles later, and
      // every vector still in flight then has a guaranteed FIFO slot.
      issue_ok_d = (state_d == ST_RUN) &&
                   ((int'(count_d) + PIPE_DEPTH + 1) <= FIFO_DEPTH) &&
                   (issued_cnt_d != beats_d);
   end

   // Control and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         beats_q      <= '0;
         rem_q        <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         issued_cnt_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         issue_ok_q   <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         beats_q      <= beats_d;
         rem_q        <= rem_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         issued_cnt_q <= issued_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         issue_ok_q   <= issue_ok_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
      end
   end

   // FIFO storage has no reset; the empty count masks stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign issue_ok = issue_ok_q;
   assign busy     = (state_q == ST_RUN);
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ew_result_collector.sv
// ---------------------------------------------------------------------------
// tb_ew_result_collector
//
// Scoreboard bench for ew_result_collector. Stimulus pushes the expected
// output beat (computed from element counts) into a queue; a monitor pops
// and compares on every AXI-Stream handshake.
// ---------------------------------------------------------------------------
module tb_ew_result_collector;

   localparam int LANES = 8;
   localparam int PIPE  = 6;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] total_elems;
   logic        valid_i;
   logic [63:0] data_i;
   logic        issue_ok;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        busy;
   logic        done;
   logic        overflow;

   ew_result_collector #(
      .MAX_VECTOR_SIZE(LANES),
      .FIFO_DEPTH(16),
      .PIPE_DEPTH(PIPE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .total_elems(total_elems),
      .valid_i(valid_i),
      .data_i(data_i),
      .issue_ok(issue_ok),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .busy(busy),
      .done(done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc = 0;
   beat_t exp_q[$];
   int    job_total = 0;
   int    job_idx = 0;
   int    out_count = 0;
   int    done_count = 0;
   int    done_base = 0;
   int    last_done_cyc = -10;
   int    last_tlast_cyc = -10;
   bit    tvalid_seen = 0;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference beat: lanes valid = elements remaining in the job, capped at 8.
   function automatic beat_t modelBeat(input int total, input int idx,
                                       input logic [63:0] raw);
      beat_t b;
      int    n;
      n = total - LANES * idx;
      if (n > LANES) n = LANES;
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < LANES; k++) begin
         if (k < n) begin
            b.data[8*k +: 8] = raw[8*k +: 8];
            b.keep[k]        = 1'b1;
         end
      end
      b.last = (LANES * (idx + 1) >= total);
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startJob(input int total);
      job_total   = total;
      job_idx     = 0;
      out_count   = 0;
      done_base   = done_count;
      start       = 1'b1;
      total_elems = total;
      tick();
      start       = 1'b0;
   endtask

   task automatic applyStimulus(input logic [63:0] raw, input bit accept);
      if (accept) begin
         exp_q.push_back(modelBeat(job_total, job_idx, raw));
         job_idx++;
      end
      valid_i = 1'b1;
      data_i  = raw;
      tick();
      valid_i = 1'b0;
   endtask

   task automatic waitDone(input int limit, input string name);
      for (int i = 0; i < limit && done_count == done_base; i++) @(negedge clk);
      checkOutput({name, "_done_seen"}, 64'(done_count - done_base), 64'd1);
      checkOutput({name, "_done_after_tlast"},
                  64'(last_done_cyc - last_tlast_cyc), 64'd1);
      checkOutput({name, "_busy_low"}, 64'(busy), 64'd0);
      @(negedge clk);
      checkOutput({name, "_done_once"}, 64'(done_count - done_base), 64'd1);
      checkOutput({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      checkOutput({name, "_tdata"}, m_axis_tdata, 64'd0);
      checkOutput({name, "_tkeep"}, 64'(m_axis_tkeep), 64'd0);
      checkOutput({name, "_tlast"}, 64'(m_axis_tlast), 64'd0);
      checkOutput({name, "_issue_ok"}, 64'(issue_ok), 64'd0);
      checkOutput({name, "_busy"}, 64'(busy), 64'd0);
      checkOutput({name, "_done"}, 64'(done), 64'd0);
      checkOutput({name, "_overflow"}, 64'(overflow), 64'd0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: compares every handshake against the scoreboard, checks that a
   // stalled beat stays put, and records done / tlast timing.
   initial begin
      logic        hold_prev;
      logic [63:0] data_prev;
      logic        rst_prev;
      beat_t       b;
      hold_prev = 1'b0;
      data_prev = '0;
      rst_prev  = 1'b0;
      forever begin
         @(negedge clk);
         if (hold_prev && !rst_prev) begin
            checkOutput("tvalid_hold", 64'(m_axis_tvalid), 64'd1);
            checkOutput("tdata_hold", m_axis_tdata, data_prev);
         end
         if (m_axis_tvalid) tvalid_seen = 1;
         if (done) begin
            done_count++;
            last_done_cyc = cyc;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("[TB] FAIL unexpected_beat: got tdata 0x%0h, expected no beat",
                        m_axis_tdata);
            end else begin
               b = exp_q.pop_front();
               checkOutput("beat_tdata", m_axis_tdata, b.data);
               checkOutput("beat_tkeep", 64'(m_axis_tkeep), 64'(b.keep));
               checkOutput("beat_tlast", 64'(m_axis_tlast), 64'(b.last));
            end
            out_count++;
            if (m_axis_tlast) last_tlast_cyc = cyc;
         end
         hold_prev = m_axis_tvalid && !m_axis_tready;
         data_prev = m_axis_tdata;
         rst_prev  = rst;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          issued;
      int          due_q[$];
      logic [63:0] dat_q[$];
      logic [63:0] raw;

      rst           = 1'b1;
      start         = 1'b0;
      total_elems   = '0;
      valid_i       = 1'b0;
      data_i        = '0;
      m_axis_tready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checkAllZero("reset");
      tick();
      rst = 1'b0;
      tick();

      // Test 1: two full beats, always ready.
      $display("[TB] test 1: 16 elements");
      m_axis_tready = 1'b1;
      startJob(16);
      applyStimulus({$urandom, $urandom}, 1);
      applyStimulus({$urandom, $urandom}, 1);
      waitDone(50, "t1");
      checkOutput("t1_beats", 64'(out_count), 64'd2);
      checkOutput("t1_overflow", 64'(overflow), 64'd0);
      tick();

      // Test 2: 13 elements, partial last beat.
      $display("[TB] test 2: 13 elements");
      startJob(13);
      applyStimulus(64'h0807060504030201, 1);
      applyStimulus(64'h100F0E0D0C0B0A09, 1);
      waitDone(50, "t2");
      checkOutput("t2_beats", 64'(out_count), 64'd2);
      tick();

      // Test 3: credit-paced upstream with PIPE-cycle latency, stalling sink.
      $display("[TB] test 3: 128 elements with backpressure");
      startJob(128);
      issued = 0;
      for (int t = 0; t < 1500 && done_count == done_base; t++) begin
         m_axis_tready = (t < 20) ? 1'b0 : 1'(t % 2);
         if (issue_ok) begin
            raw = {$urandom, $urandom};
            due_q.push_back(cyc + PIPE);
            dat_q.push_back(raw);
            exp_q.push_back(modelBeat(job_total, job_idx, raw));
            job_idx++;
            issued++;
         end
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            valid_i = 1'b1;
            data_i  = dat_q.pop_front();
            void'(due_q.pop_front());
         end else begin
            valid_i = 1'b0;
         end
         tick();
      end
      valid_i = 1'b0;
      m_axis_tready = 1'b1;
      checkOutput("t3_done_seen", 64'(done_count - done_base), 64'd1);
      checkOutput("t3_done_after_tlast", 64'(last_done_cyc - last_tlast_cyc), 64'd1);
      checkOutput("t3_issued", 64'(issued), 64'd16);
      checkOutput("t3_beats", 64'(out_count), 64'd16);
      checkOutput("t3_overflow", 64'(overflow), 64'd0);
      checkOutput("t3_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();

      // Test 4: one-beat job followed by a surplus beat.
      $display("[TB] test 4: surplus beat");
      startJob(8);
      applyStimulus({$urandom, $urandom}, 1);
      applyStimulus({$urandom, $urandom}, 0);
      @(negedge clk);
      checkOutput("t4_overflow", 64'(overflow), 64'd1);
      waitDone(50, "t4");
      checkOutput("t4_beats", 64'(out_count), 64'd1);
      repeat (3) tick();
      checkOutput("t4_no_extra_beat", 64'(out_count), 64'd1);
      checkOutput("t4_overflow_sticky", 64'(overflow), 64'd1);

      // Test 5: zero-length job.
      $display("[TB] test 5: zero elements");
      tvalid_seen = 0;
      startJob(0);
      @(negedge clk);
      checkOutput("t5_done", 64'(done), 64'd1);
      checkOutput("t5_busy", 64'(busy), 64'd0);
      checkOutput("t5_overflow_cleared", 64'(overflow), 64'd0);
      repeat (4) tick();
      checkOutput("t5_done_once", 64'(done_count - done_base), 64'd1);
      checkOutput("t5_no_tvalid", 64'(tvalid_seen), 64'd0);

      // Beat arriving while idle is dropped and flagged.
      applyStimulus({$urandom, $urandom}, 0);
      @(negedge clk);
      checkOutput("idle_drop_overflow", 64'(overflow), 64'd1);
      tick();

      // Test 6: reset mid-job, then a fresh job.
      $display("[TB] test 6: reset mid-job");
      m_axis_tready = 1'b0;
      startJob(80);
      @(negedge clk);
      checkOutput("t6_start_clears_overflow", 64'(overflow), 64'd0);
      checkOutput("t6_busy", 64'(busy), 64'd1);
      tick();
      for (int i = 0; i < 3; i++) applyStimulus({$urandom, $urandom}, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("t6_after_rst");
      exp_q.delete();
      done_base = done_count;
      repeat (5) tick();
      checkOutput("t6_no_done", 64'(done_count - done_base), 64'd0);
      m_axis_tready = 1'b1;
      startJob(8);
      applyStimulus({$urandom, $urandom}, 1);
      waitDone(50, "t6");
      checkOutput("t6_beats", 64'(out_count), 64'd1);
      checkOutput("t6_overflow", 64'(overflow), 64'd0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ew_result_collector.md
Name: ew_result_collector

Overview:
- Sink-side companion of the 8-lane elementwise quantized ALU vector blocks (ADD/SUB family). It captures their unbackpressured result stream (data_o/valid_o) into a FIFO.
- It re-emits the results as an AXI-Stream master toward the output DMA/buffer writer, with tlast and tkeep derived from the programmed element count.
- It gives the upstream issue logic a credit signal (issue_ok) so no result beat is ever lost.

Parameters:
- MAX_VECTOR_SIZE, 8, int8 lanes per beat.
- FIFO_DEPTH, 16, result FIFO entries (power of 2).
- PIPE_DEPTH, 6, maximum ALU latency in cycles from issue to valid_i. Legal only when FIFO_DEPTH > PIPE_DEPTH+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse; latches total_elems and begins a job (ignored unless IDLE).
- total_elems  in  32  number of int8 results in the job.
- valid_i  in  1  result beat valid (from ALU valid_o).
- data_i  in  INT8_SIZE*MAX_VECTOR_SIZE  result beat (from ALU data_o); lane k = bits[8k+7:8k].
- issue_ok  out  1  registered; upstream may issue a new vector into the ALU this cycle.
- m_axis_tdata  out  INT8_SIZE*MAX_VECTOR_SIZE  output beat.
- m_axis_tkeep  out  MAX_VECTOR_SIZE  byte enables.
- m_axis_tlast  out  1  final beat of job.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high in RUN.
- done  out  1  1-cycle pulse at job end.
- overflow  out  1  sticky error: a beat was dropped.

Behaviour:
- Reset values: all outputs 0, FIFO empty, counters 0, state IDLE. Reset mid-job aborts the job with no done pulse and clears overflow.
- States are IDLE and RUN.
- IDLE -> RUN on start with total_elems != 0.
  - Latch beats = ceil(total_elems/8) and rem = total_elems[2:0].
  - Clear in_cnt, out_cnt and overflow.
- start with total_elems == 0 in IDLE: done pulses the next cycle, no beats are emitted, the state stays IDLE, and overflow is cleared.
- start while in RUN is ignored.
- Push path: valid_i pushes data_i when state==RUN, in_cnt<beats, and (FIFO not full or a pop occurs the same cycle). Each push increments in_cnt.
- Any valid_i that is not pushed sets overflow and the data is dropped. This covers IDLE, surplus beats (in_cnt==beats), and FIFO full without a pop.
- FIFO latency: a push into an empty FIFO raises tvalid the next cycle; there is no combinational bypass. Simultaneous push/pop keeps the count unchanged.
- Output path:
  - m_axis_tvalid = FIFO not empty. tdata = FIFO head. tdata and tvalid are held stable while tvalid && !tready.
  - A handshake (tvalid && tready) pops the FIFO and increments out_cnt.
  - tlast = (out_cnt == beats-1) and tvalid.
  - tkeep = 0xFF, except on the tlast beat when rem != 0, where tkeep = (1<<rem)-1. Lanes with tkeep=0 drive tdata zero.
- Completion: on the tlast handshake the state returns to IDLE at the next edge and done pulses in that same next cycle. busy drops with done. overflow persists until the next start or rst.
- Credit: issue_ok is registered; next value = (state==RUN) && (fifo_count + PIPE_DEPTH + 1 <= FIFO_DEPTH) && (issued_cnt < beats).
  - issued_cnt increments for every cycle issue_ok is high. Upstream issues exactly one vector per cycle while issue_ok is high.
  - This guarantees no overflow under any tready pattern when upstream obeys issue_ok.
- Order is strictly FIFO; no reordering and no data modification other than tkeep-masked lane zeroing.
- Counter widths: 30-bit beat counters (ceil of 32-bit/8). Compare with equality only; no wrap within a job.

Test Plan:
1. total_elems=16, 2 pushes, tready=1 -> 2 beats with tkeep=0xFF, tlast on beat 2, done one cycle after the final handshake, overflow=0.
2. total_elems=13, lanes=0x01..0x10 -> beat 2 tkeep=0x1F, tdata bits[63:40]=0, tlast=1.
3. total_elems=128, tready low for 20 cycles then toggling 1/0, upstream gated by issue_ok with PIPE_DEPTH=6 latency -> 16 beats in order, overflow never set, fifo_count never exceeds 16.
4. total_elems=8, then 2 valid_i beats -> 1 beat output with tlast, overflow=1 after the 2nd beat, no 2nd output beat.
5. start with total_elems=0 -> done next cycle, tvalid never asserted, busy stays 0.
6. rst asserted after 3 of 10 beats pushed -> all outputs 0 next cycle with no done. A new start with total_elems=8 then completes normally.
